uart_rx: RTL and testbench

Serial receiver for the UART link, the receive-side counterpart of the UART transmitter. It oversamples `rx_in` at `prescale` clocks per bit and detects the start bit with glitch rejection. It recovers LSB-first data with a 3-sample majority vote, then checks optional parity and the stop bit. It presents a parallel word with a one-cycle `data_valid` strobe to the downstream consumer, e.g. a FIFO or register file.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 54 +++++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity selectors and prescale constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter, mid-bit triple capture and majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_s,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  bit_valid,
    output logic                  bit_end
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic [2:0]            samp;

    assign half = {1'b0, prescale[PRESCALE_W-1:1]};
    assign last = prescale - ONE;

    // run is the owner's next-state-active flag, so the counter is already 0
    // in the cycle the FSM returns to IDLE and a new start bit lines up exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!run || edge_cnt == last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= 3'b111;
        end else begin
            if (edge_cnt == half - ONE) samp[0] <= rx_s;
            if (edge_cnt == half)       samp[1] <= rx_s;
            if (edge_cnt == half + ONE) samp[2] <= rx_s;
        end
    end

    assign sampled_bit = majority3(samp[0], samp[1], samp[2]);
    assign bit_valid   = (edge_cnt == half + TWO);
    assign bit_end     = (edge_cnt == last);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity/stop checking and strobe outputs
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    uart_state_e state, state_next;

    logic                  rx_meta, rx_s;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic                  cfg_par_en, cfg_par_typ;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_flag, stp_flag;

    logic sampled_bit, bit_valid, bit_end;
    logic run;
    logic start_det, shift_en, bit_adv, par_chk, stp_chk, frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign run = (state_next != IDLE);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_s        (rx_s),
        .run         (run),
        .prescale    (cfg_prescale),
        .sampled_bit (sampled_bit),
        .bit_valid   (bit_valid),
        .bit_end     (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!rx_s) state_next = START;
            START: begin
                // A high majority at mid-bit means the falling edge was noise.
                if (bit_valid && sampled_bit) state_next = IDLE;
                else if (bit_end)             state_next = DATA;
            end
            DATA:    if (bit_end && bit_cnt == LAST_BIT)
                         state_next = cfg_par_en ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        start_det  = 1'b0;
        shift_en   = 1'b0;
        bit_adv    = 1'b0;
        par_chk    = 1'b0;
        stp_chk    = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE:   start_det  = !rx_s;
            DATA: begin
                shift_en = bit_valid;
                bit_adv  = bit_end;
            end
            PARITY: par_chk    = bit_valid;
            STOP: begin
                stp_chk    = bit_valid;
                frame_done = bit_end;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_prescale <= PRESCALE_W'(PRESCALE_8);
            cfg_par_en   <= 1'b0;
            cfg_par_typ  <= PAR_EVEN;
        end else if (start_det) begin
            cfg_prescale <= prescale;
            cfg_par_en   <= par_en;
            cfg_par_typ  <= par_typ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            par_flag <= 1'b0;
            stp_flag <= 1'b0;
        end else begin
            if (start_det) begin
                bit_cnt  <= '0;
                par_flag <= 1'b0;
                stp_flag <= 1'b0;
            end
            if (shift_en) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            if (bit_adv)  bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
            if (par_chk && (sampled_bit != (^shreg ^ cfg_par_typ))) par_flag <= 1'b1;
            if (stp_chk && !sampled_bit) stp_flag <= 1'b1;
        end
    end

    // p_data only moves on a clean frame so the consumer always sees the last good word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (frame_done) begin
                data_valid <= !(par_flag || stp_flag);
                par_err    <= par_flag;
                stp_err    <= stp_flag;
                if (!(par_flag || stp_flag)) p_data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid, par_err, stp_err;

    uart_rx #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       dv;
        bit       pe;
        bit       se;
        bit [7:0] data;
        int       at;
    } exp_t;

    exp_t     sb[$];
    int       checks = 0;
    int       errors = 0;
    bit [7:0] last_good = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: dv=%0d pe=%0d se=%0d with nothing expected at cycle %0d",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                e = sb.pop_front();
                chk("data_valid", int'(data_valid), int'(e.dv));
                chk("par_err", int'(par_err), int'(e.pe));
                chk("stp_err", int'(stp_err), int'(e.se));
                chk("p_data", int'(p_data), int'(e.data));
                chk("strobe_cycle", cyc, e.at);
            end
        end
    end

    task automatic slot(input bit v);
        rx_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b1);
    endtask

    // Frame model: bit list built from the frame format; strobe lands N*p+2 cycles after the start edge.
    task automatic send_frame(input bit [7:0] d, input int p, input bit pe, input bit pt,
                              input bit bad_par, input bit bad_stop, input bit noise,
                              input bit scramble);
        bit   bits[$];
        bit   parb;
        bit   v;
        int   r;
        exp_t e;
        prescale = PW'(p);
        par_en   = pe;
        par_typ  = pt;
        parb = (^d) ^ pt;
        if (bad_par) parb = ~parb;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(parb);
        bits.push_back(!bad_stop);
        e.pe = pe && bad_par;
        e.se = bad_stop;
        e.dv = !(e.pe || e.se);
        if (e.dv) last_good = d;
        e.data = last_good;
        e.at = cyc + bits.size() * p + 2;
        sb.push_back(e);
        for (int j = 0; j < bits.size(); j++) begin
            r = int'($urandom_range(0, 2));
            for (int o = 0; o < p; o++) begin
                v = bits[j];
                if (noise && o == p / 2 - 1 + r) v = ~v;
                slot(v);
                if (scramble && j == 0 && o == p - 1) begin
                    prescale = PW'((p == 8) ? 32 : 8);
                    par_en   = !pe;
                    par_typ  = !pt;
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_p_data"}, int'(p_data), 0);
        chk({tag, "_data_valid"}, int'(data_valid), 0);
        chk({tag, "_par_err"}, int'(par_err), 0);
        chk({tag, "_stp_err"}, int'(stp_err), 0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit [7:0] abort_d;
        int       p, w, j;
        bit       pe;
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0);
        idle(4);
        send_frame(8'h3C, 8, 1, 0, 0, 0, 0, 0);
        idle(4);
        send_frame(8'h3C, 8, 1, 0, 1, 0, 0, 0);
        idle(4);
        send_frame(8'h81, 16, 1, 1, 0, 1, 0, 0);
        idle(4);

        prescale = PW'(8);
        par_en = 1'b0;
        slot(1'b0);
        slot(1'b0);
        idle(24);
        send_frame(8'h5A, 8, 0, 0, 0, 0, 0, 0);
        idle(4);
        send_frame(8'hF0, 8, 0, 0, 0, 0, 1, 0);
        idle(4);
        send_frame(8'h01, 8, 0, 0, 0, 0, 0, 0);
        send_frame(8'hFE, 8, 0, 0, 0, 0, 0, 0);
        idle(30);

        abort_d = 8'hC3;
        prescale = PW'(8);
        par_en = 1'b0;
        for (int s = 0; s < 44; s++) begin
            j = s / 8;
            slot((j == 0) ? 1'b0 : abort_d[(j == 0) ? 0 : j - 1]);
        end
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check_outputs_zero("midframe_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(5);
        check_outputs_zero("after_reset");
        send_frame(8'h77, 8, 0, 0, 0, 0, 0, 0);
        idle(4);

        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pe = bit'($urandom_range(0, 1));
            send_frame(8'($urandom), p, pe, bit'($urandom_range(0, 1)),
                       pe && ($urandom_range(0, 4) == 0), $urandom_range(0, 6) == 0,
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)));
        end

        w = 0;
        while (sb.size() > 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        idle(50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
